// File: rtl/clm_subbytes_seq_pkg.sv
// clm_subbytes_seq_pkg: shared types for the CLM SubBytes sequencer
//   M / D             : plain byte width and default redundancy width
//   state_t           : one encoded word (M+D bits)
//   sbox_rnd_t        : seven mask words fed to the S-box core per launch
//   subbytes_state_e  : sequencer FSM states
package clm_subbytes_seq_pkg;
    localparam int M = 8;
    localparam int D = 8;
    typedef logic [M+D-1:0] state_t;
    typedef state_t [6:0] sbox_rnd_t;
    typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_DONE} subbytes_state_e;
endpackage

// File: rtl/clm_subbytes_seq.sv
// clm_subbytes_seq: runs a 16-word SubBytes layer through one shared CLM S-box core
//   clk, rst          : clock, asynchronous active-high reset
//   start             : begin a layer (sampled only while idle)
//   state_in          : encoded input state, captured on an accepted start
//   rnd_in / rnd_req  : fresh mask words / pulse when they are consumed
//   state_out         : in-place result buffer
//   busy, done, err   : layer active, layer complete pulse, sticky timeout
//   sbox_in, sbox_r, sbox_drdy_i : word, masks and launch strobe to the core
//   sbox_out, sbox_drdy_o        : result and one-cycle valid from the core
module clm_subbytes_seq
    import clm_subbytes_seq_pkg::*;
#(
    parameter int d        = D,
    parameter int NBYTES   = 16,
    parameter int WAIT_MAX = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [NBYTES-1:0][M+d-1:0]   state_in,
    input  logic [6:0][M+d-1:0]          rnd_in,
    output logic                         rnd_req,
    output logic [NBYTES-1:0][M+d-1:0]   state_out,
    output logic                         busy,
    output logic                         done,
    output logic                         err,
    output logic [M+d-1:0]               sbox_in,
    output logic [6:0][M+d-1:0]          sbox_r,
    output logic                         sbox_drdy_i,
    input  logic [M+d-1:0]               sbox_out,
    input  logic                         sbox_drdy_o
);
    localparam int IW = NBYTES > 1 ? $clog2(NBYTES) : 1;
    localparam int CW = WAIT_MAX > 1 ? $clog2(WAIT_MAX) : 1;

    subbytes_state_e             st, st_n;
    logic [NBYTES-1:0][M+d-1:0]  buf_q;
    logic [6:0][M+d-1:0]         r_q;
    logic [IW-1:0]               idx;
    logic [CW-1:0]               wait_cnt;
    logic                        accept, hit, last, timeout;

    assign accept  = st == S_IDLE && start;
    assign hit     = st == S_WAIT && sbox_drdy_o;
    assign last    = idx == IW'(NBYTES - 1);
    assign timeout = st == S_WAIT && !sbox_drdy_o && wait_cnt == CW'(WAIT_MAX - 1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= S_IDLE;
        else     st <= st_n;
    end

    always_comb begin
        st_n = st;
        case (st)
            S_IDLE:   st_n = start ? S_LAUNCH : S_IDLE;
            S_LAUNCH: st_n = S_WAIT;
            S_WAIT:   st_n = sbox_drdy_o ? (last ? S_DONE : S_LAUNCH) : (timeout ? S_IDLE : S_WAIT);
            default:  st_n = S_IDLE;
        endcase
    end

    // Masks are refreshed exactly when r_q loads: on accept and after each non-final result.
    always_comb begin
        rnd_req     = accept || (hit && !last);
        sbox_drdy_i = st == S_LAUNCH;
        busy        = st != S_IDLE;
        done        = st == S_DONE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q    <= '0;
            r_q      <= '0;
            idx      <= '0;
            wait_cnt <= '0;
            err      <= 1'b0;
        end else begin
            if (accept) begin
                buf_q <= state_in;
                idx   <= '0;
                err   <= 1'b0;
            end
            if (rnd_req) r_q <= rnd_in;
            if (st == S_LAUNCH)    wait_cnt <= '0;
            else if (st == S_WAIT) wait_cnt <= wait_cnt + 1'b1;
            // A timeout leaves the buffer partially updated; the caller sees err.
            if (hit) begin
                buf_q[idx] <= sbox_out;
                if (!last) idx <= idx + 1'b1;
            end
            if (timeout) err <= 1'b1;
        end
    end

    // The word and its masks come straight from registers, so they stay put
    // from LAUNCH until the result is written back.
    assign sbox_in   = buf_q[idx];
    assign sbox_r    = r_q;
    assign state_out = buf_q;
endmodule

// File: tb/tb_clm_subbytes_seq.sv
// tb_clm_subbytes_seq: randomized self-checking bench with an AES S-box core model
module tb_clm_subbytes_seq;
    import clm_subbytes_seq_pkg::*;
    localparam int N = 16;
    localparam int W = M + D;

    logic clk = 1'b0, rst = 1'b1, start = 1'b0;
    logic [N-1:0][W-1:0] state_in = '0, state_out;
    logic [6:0][W-1:0]   rnd_in, sbox_r;
    logic                rnd_req, busy, done, err, sbox_drdy_i, sbox_drdy_o;
    logic [W-1:0]        sbox_in, sbox_out;

    int total = 0, bad = 0;

    always #5 clk = ~clk;

    clm_subbytes_seq #(.d(D), .NBYTES(N), .WAIT_MAX(8)) dut (
        .clk(clk), .rst(rst), .start(start), .state_in(state_in), .rnd_in(rnd_in),
        .rnd_req(rnd_req), .state_out(state_out), .busy(busy), .done(done), .err(err),
        .sbox_in(sbox_in), .sbox_r(sbox_r), .sbox_drdy_i(sbox_drdy_i),
        .sbox_out(sbox_out), .sbox_drdy_o(sbox_drdy_o)
    );

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    // AES S-box from first principles: GF(2^8) inverse (a^254) then the affine map.
    function automatic logic [7:0] aes_sbox(input logic [7:0] a);
        logic [7:0] v = 8'h01;
        for (int i = 0; i < 254; i++) v = gmul(v, a);
        return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
    endfunction

    // Core behaviour: identity encoding on the low byte, redundancy re-masked with r[3].
    function automatic logic [W-1:0] core_fn(input logic [W-1:0] x, input logic [6:0][W-1:0] r);
        return {x[W-1:M] ^ r[3][W-1:M], aes_sbox(x[M-1:0])};
    endfunction

    // Random mask source: advances one entry per rnd_req.
    logic [6:0][W-1:0] rnd_seq [256];
    int rnd_ptr = 0;
    assign rnd_in = rnd_seq[rnd_ptr % 256];

    int edges = 0, done_at = -1, n_done = 0, n_req = 0;
    always @(posedge clk) begin
        edges <= edges + 1;
        if (done) begin
            done_at <= edges;
            n_done  <= n_done + 1;
        end
        if (rnd_req) begin
            n_req   <= n_req + 1;
            rnd_ptr <= rnd_ptr + 1;
        end
    end

    // Core model: result valid 6 cycles after launch; also watches input stability.
    bit core_en = 1'b1;
    int ccnt = 0, unstable = 0;
    logic [W-1:0]      c_in = '0;
    logic [6:0][W-1:0] c_r = '0;
    always @(posedge clk or posedge rst) begin
        if (rst) ccnt <= 0;
        else if (ccnt != 0) begin
            if (sbox_in !== c_in || sbox_r !== c_r) unstable <= unstable + 1;
            ccnt <= ccnt == 6 ? 0 : ccnt + 1;
        end else if (sbox_drdy_i && core_en) begin
            ccnt <= 1;
            c_in <= sbox_in;
            c_r  <= sbox_r;
        end
    end
    assign sbox_drdy_o = ccnt == 6;
    assign sbox_out    = sbox_drdy_o ? core_fn(c_in, c_r) : '0;

    logic [N-1:0][W-1:0] cur_in;
    int p0, c0, req0, done0, unst0;

    task automatic launch_layer();
        state_in = cur_in;
        start = 1'b1;
        p0 = rnd_ptr; c0 = edges; req0 = n_req; done0 = n_done; unst0 = unstable;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int ign_a, input int ign_b, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (edges - c0 == ign_a || edges - c0 == ign_b) begin
                start = 1'b1;
                state_in = ~cur_in;
            end
            @(posedge clk); #1;
            start = 1'b0;
            state_in = cur_in;
            ok = n_done != done0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        req0 = n_req;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            total++;
            if ({busy, done, err, rnd_req, sbox_drdy_i} !== 5'b0 || sbox_in !== '0 || sbox_r !== '0 || state_out !== '0) begin
                bad++;
                $display("FAIL reset_idle cyc=%0d got busy=%b done=%b err=%b req=%b drdy_i=%b in=%h out_nz=%b want all 0",
                         i, busy, done, err, rnd_req, sbox_drdy_i, sbox_in, state_out != '0);
            end
        end
        total++;
        if (n_req !== req0) begin
            bad++;
            $display("FAIL reset_rnd_req got %0d pulses want 0", n_req - req0);
        end
    endtask

    task automatic test_plain();
        bit ok;
        for (int k = 0; k < N; k++) cur_in[k] = W'(k);
        launch_layer();
        wait_done(-1, -1, ok);
        total++;
        if (!ok || done_at - c0 != 113) begin
            bad++;
            $display("FAIL plain_done_cycle got %0d (seen=%0d) want 113", done_at - c0, ok);
        end
        total++;
        if (state_out[0][7:0] !== 8'h63 || state_out[1][7:0] !== 8'h7C || state_out[15][7:0] !== 8'h76) begin
            bad++;
            $display("FAIL plain_known got %h %h %h want 63 7c 76",
                     state_out[0][7:0], state_out[1][7:0], state_out[15][7:0]);
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (state_out[k] !== core_fn(cur_in[k], rnd_seq[(p0 + k) % 256])) begin
                bad++;
                $display("FAIL plain_word%0d got %h want %h", k, state_out[k], core_fn(cur_in[k], rnd_seq[(p0 + k) % 256]));
            end
        end
        total++;
        if (busy !== 1'b0 || err !== 1'b0) begin
            bad++;
            $display("FAIL plain_after got busy=%b err=%b want 0 0", busy, err);
        end
    endtask

    task automatic test_masked();
        bit ok;
        for (int k = 0; k < N; k++) cur_in[k] = {8'($urandom), 8'h53};
        launch_layer();
        wait_done(-1, -1, ok);
        for (int k = 0; k < N; k++) begin
            total++;
            if (state_out[k][7:0] !== 8'hED || state_out[k] !== core_fn(cur_in[k], rnd_seq[(p0 + k) % 256])) begin
                bad++;
                $display("FAIL masked_word%0d got %h want %h", k, state_out[k], core_fn(cur_in[k], rnd_seq[(p0 + k) % 256]));
            end
        end
        total++;
        if (n_req - req0 != N) begin
            bad++;
            $display("FAIL masked_rnd_req got %0d want %0d", n_req - req0, N);
        end
        total++;
        if (unstable != unst0) begin
            bad++;
            $display("FAIL masked_stability got %0d unstable cycles want 0", unstable - unst0);
        end
    endtask

    task automatic test_ignored_start();
        bit ok;
        for (int k = 0; k < N; k++) cur_in[k] = W'($urandom);
        launch_layer();
        wait_done(5, 50, ok);
        repeat (10) @(posedge clk);
        #1;
        total++;
        if (!ok || done_at - c0 != 113 || n_done - done0 != 1) begin
            bad++;
            $display("FAIL ignored_start got done_cycle=%0d dones=%0d want 113 1", done_at - c0, n_done - done0);
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (state_out[k] !== core_fn(cur_in[k], rnd_seq[(p0 + k) % 256])) begin
                bad++;
                $display("FAIL ignored_word%0d got %h want %h", k, state_out[k], core_fn(cur_in[k], rnd_seq[(p0 + k) % 256]));
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        for (int k = 0; k < N; k++) cur_in[k] = W'($urandom);
        launch_layer();
        wait_done(-1, -1, ok);
        for (int k = 0; k < N; k++) cur_in[k] = W'($urandom);
        launch_layer();
        total++;
        if (busy !== 1'b1) begin
            bad++;
            $display("FAIL b2b_accept got busy=%b want 1", busy);
        end
        wait_done(-1, -1, ok);
        total++;
        if (!ok || done_at - c0 != 113) begin
            bad++;
            $display("FAIL b2b_done_cycle got %0d want 113", done_at - c0);
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (state_out[k] !== core_fn(cur_in[k], rnd_seq[(p0 + k) % 256])) begin
                bad++;
                $display("FAIL b2b_word%0d got %h want %h", k, state_out[k], core_fn(cur_in[k], rnd_seq[(p0 + k) % 256]));
            end
        end
    endtask

    task automatic test_timeout();
        bit ok;
        for (int k = 0; k < N; k++) cur_in[k] = W'($urandom);
        core_en = 1'b0;
        launch_layer();
        repeat (8) @(posedge clk);
        #1;
        total++;
        if (err !== 1'b0 || busy !== 1'b1) begin
            bad++;
            $display("FAIL timeout_cyc9 got err=%b busy=%b want 0 1", err, busy);
        end
        @(posedge clk); #1;
        total++;
        if (err !== 1'b1 || busy !== 1'b0 || state_out !== cur_in) begin
            bad++;
            $display("FAIL timeout_flag got err=%b busy=%b buf_kept=%b want 1 0 1", err, busy, state_out === cur_in);
        end
        repeat (3) @(posedge clk);
        #1;
        total++;
        if (err !== 1'b1) begin
            bad++;
            $display("FAIL timeout_sticky got err=%b want 1", err);
        end
        core_en = 1'b1;
        launch_layer();
        total++;
        if (err !== 1'b0) begin
            bad++;
            $display("FAIL timeout_clear got err=%b want 0", err);
        end
        wait_done(-1, -1, ok);
        total++;
        if (!ok || state_out[7] !== core_fn(cur_in[7], rnd_seq[(p0 + 7) % 256])) begin
            bad++;
            $display("FAIL timeout_recover got %h want %h", state_out[7], core_fn(cur_in[7], rnd_seq[(p0 + 7) % 256]));
        end
    endtask

    task automatic test_rst_mid();
        bit ok;
        int ca;
        for (int k = 0; k < N; k++) cur_in[k] = W'($urandom);
        launch_layer();
        ca = c0;
        while (edges - ca < 40) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        #1;
        total++;
        if (busy !== 1'b0 || state_out !== '0 || sbox_r !== '0 || err !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_clear got busy=%b buf_nz=%b r_nz=%b err=%b want 0 0 0 0",
                     busy, state_out != '0, sbox_r != '0, err);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        while (edges - ca < 45) begin
            @(posedge clk); #1;
        end
        for (int k = 0; k < N; k++) cur_in[k] = W'($urandom);
        launch_layer();
        wait_done(-1, -1, ok);
        total++;
        if (!ok || done_at - ca != 158) begin
            bad++;
            $display("FAIL rst_mid_done_cycle got %0d want 158", done_at - ca);
        end
        for (int k = 0; k < N; k++) begin
            total++;
            if (state_out[k] !== core_fn(cur_in[k], rnd_seq[(p0 + k) % 256])) begin
                bad++;
                $display("FAIL rst_mid_word%0d got %h want %h", k, state_out[k], core_fn(cur_in[k], rnd_seq[(p0 + k) % 256]));
            end
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++)
            for (int j = 0; j < 7; j++) rnd_seq[i][j] = W'($urandom);
        test_reset();
        test_plain();
        test_masked();
        test_ignored_start();
        test_back_to_back();
        test_timeout();
        test_rst_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
